// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//
// Write-back arbiter feeding the single register-file write port. Three write
// sources (load return, ALU result, JAL link) are merged into an in-order
// pending-write FIFO. The FIFO head is popped into a registered write port
// (regwr/rw/busw) at most once per cycle. Pending writes, including the one
// currently held in the output register, can be looked up for operand
// forwarding. A conservative stall tells the front end to hold off while
// fewer than three free slots remain.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   ld_vld/ld_rd/ld_data    load-return write request
//   alu_vld/alu_rd/alu_data ALU write request
//   jal_vld/jal_ins         JAL link request, link value = {jal_ins, 2'b00}
//   busw, rw, regwr         registered write port into the register file
//   stall                   back-pressure to all sources
//   ovf                     sticky flag, set when any request is dropped
//   ra, rb                  forwarding lookup addresses
//   hit_a/fwd_a, hit_b/fwd_b  youngest pending write data for ra / rb
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_vld,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_vld,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  input  logic          jal_vld,
  input  logic [29:0]   jal_ins,
  output logic [DW-1:0] busw,
  output logic [AW-1:0] rw,
  output logic          regwr,
  output logic          stall,
  output logic          ovf,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          hit_a,
  output logic          hit_b,
  output logic [DW-1:0] fwd_a,
  output logic [DW-1:0] fwd_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NSRC = 3;

  // Link register: all-ones address (r31 for the default AW of 5).
  localparam logic [AW-1:0] LINK_REG = '1;

  // Pending-write storage. Entries are only ever read when they are valid
  // (inside the head..head+count window), so the array itself needs no reset.
  logic [AW-1:0] mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  // Candidate writes in enqueue priority order: 0 = ld, 1 = alu, 2 = jal.
  logic [NSRC-1:0] src_vld;
  logic [AW-1:0]   src_rd   [NSRC];
  logic [DW-1:0]   src_data [NSRC];

  logic [NSRC-1:0] push_en;
  logic [PW-1:0]   push_idx [NSRC];
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   room;
  logic            drop;
  logic            pop;

  // Writes to r0 are discarded before they can take a slot.
  always_comb begin
    src_vld[0]  = ld_vld  && (ld_rd  != '0);
    src_rd[0]   = ld_rd;
    src_data[0] = ld_data;
    src_vld[1]  = alu_vld && (alu_rd != '0);
    src_rd[1]   = alu_rd;
    src_data[1] = alu_data;
    src_vld[2]  = jal_vld;
    src_rd[2]   = LINK_REG;
    src_data[2] = DW'({jal_ins, 2'b00});
  end

  // Slot allocation. Free room is judged on the registered count only: the
  // slot being popped this edge is not reused until the next edge. Accepted
  // requests take consecutive slots from the tail; anything that does not
  // fit is dropped and flags overflow.
  always_comb begin
    room    = CW'(DEPTH) - count;
    push_n  = '0;
    push_en = '0;
    drop    = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      push_idx[s] = '0;
      if (src_vld[s]) begin
        if (push_n < room) begin
          push_en[s]  = 1'b1;
          push_idx[s] = tail + PW'(push_n);
          push_n      = push_n + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Only entries already present before this edge may be popped.
  assign pop = (count != '0);

  // Leaves room for a full three-way push on the next edge.
  assign stall = (count > CW'(DEPTH - 3));

  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (push_en[s]) begin
        mem_rd[push_idx[s]]   <= src_rd[s];
        mem_data[push_idx[s]] <= src_data[s];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      regwr <= 1'b0;
      rw    <= '0;
      busw  <= '0;
      ovf   <= 1'b0;
    end else begin
      tail  <= tail + PW'(push_n);
      head  <= head + PW'(pop);
      count <= count + push_n - CW'(pop);
      ovf   <= ovf | drop;
      if (pop) begin
        regwr <= 1'b1;
        rw    <= mem_rd[head];
        busw  <= mem_data[head];
      end else begin
        regwr <= 1'b0;
      end
    end
  end

  // Forwarding lookup: returns {hit, data}. The output register is the
  // oldest candidate, then FIFO entries from head to newest; later matches
  // overwrite earlier ones so the youngest write wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] addr);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    if (addr != '0) begin
      if (regwr && (rw == addr)) begin
        res = {1'b1, busw};
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count) && (mem_rd[idx] == addr)) begin
          res = {1'b1, mem_data[idx]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    {hit_a, fwd_a} = lookup(ra);
    {hit_b, fwd_b} = lookup(rb);
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_vld;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_vld;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        jal_vld;
  logic [29:0] jal_ins;
  logic [31:0] busw;
  logic [4:0]  rw;
  logic        regwr;
  logic        stall;
  logic        ovf;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        hit_a;
  logic        hit_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  int checks;
  int failures;

  wb_write_arbiter #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_vld(ld_vld), .ld_rd(ld_rd), .ld_data(ld_data),
    .jal_vld(jal_vld), .jal_ins(jal_ins),
    .busw(busw), .rw(rw), .regwr(regwr), .stall(stall), .ovf(ovf),
    .ra(ra), .rb(rb), .hit_a(hit_a), .hit_b(hit_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_vld = 0; alu_rd = 0; alu_data = 0;
    ld_vld = 0; ld_rd = 0; ld_data = 0;
    jal_vld = 0; jal_ins = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs(); ra = 0; rb = 0;
    #3;
    checks++; if (regwr !== 1'b0) begin failures++; $display("FAIL rst_regwr got=%0h exp=0", regwr); end
    checks++; if (rw !== 5'd0) begin failures++; $display("FAIL rst_rw got=%0h exp=0", rw); end
    checks++; if (busw !== 32'd0) begin failures++; $display("FAIL rst_busw got=%0h exp=0", busw); end
    checks++; if (stall !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL rst_stall_ovf got=%0b%0b exp=00", stall, ovf); end
    checks++; if (hit_a !== 1'b0 || hit_b !== 1'b0 || fwd_a !== 32'd0 || fwd_b !== 32'd0) begin failures++; $display("FAIL rst_fwd got=%0b%0b %0h %0h exp=00 0 0", hit_a, hit_b, fwd_a, fwd_b); end
    #9;
    reset = 0;
  endtask

  task automatic test_single_alu();
    alu_vld = 1; alu_rd = 5; alu_data = 32'h1234; ra = 5;
    tick();   // edge 1: request sampled
    clear_inputs();
    checks++; if (regwr !== 1'b0) begin failures++; $display("FAIL alu_e1_regwr got=%0h exp=0", regwr); end
    checks++; if (hit_a !== 1'b1 || fwd_a !== 32'h1234) begin failures++; $display("FAIL alu_e1_fwd got=%0b %0h exp=1 1234", hit_a, fwd_a); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_e1_stall got=%0h exp=0", stall); end
    tick();   // edge 2: popped into output register
    checks++; if (regwr !== 1'b1 || rw !== 5'd5 || busw !== 32'h1234) begin failures++; $display("FAIL alu_e2_write got=%0b %0d %0h exp=1 5 1234", regwr, rw, busw); end
    checks++; if (hit_a !== 1'b1 || fwd_a !== 32'h1234) begin failures++; $display("FAIL alu_e2_fwd_outreg got=%0b %0h exp=1 1234", hit_a, fwd_a); end
    tick();   // edge 3: idle, rw/busw hold
    checks++; if (regwr !== 1'b0 || rw !== 5'd5 || busw !== 32'h1234) begin failures++; $display("FAIL alu_e3_hold got=%0b %0d %0h exp=0 5 1234", regwr, rw, busw); end
    checks++; if (hit_a !== 1'b0) begin failures++; $display("FAIL alu_e3_nohit got=%0h exp=0", hit_a); end
  endtask

  task automatic test_simultaneous();
    ld_vld = 1; ld_rd = 3; ld_data = 32'hA;
    alu_vld = 1; alu_rd = 4; alu_data = 32'hB;
    jal_vld = 1; jal_ins = 30'h100;
    rb = 31;
    tick();
    clear_inputs();
    checks++; if (stall !== 1'b1 || regwr !== 1'b0) begin failures++; $display("FAIL sim_e1 got stall=%0b regwr=%0b exp stall=1 regwr=0", stall, regwr); end
    checks++; if (hit_b !== 1'b1 || fwd_b !== 32'h400) begin failures++; $display("FAIL sim_jal_fwd got=%0b %0h exp=1 400", hit_b, fwd_b); end
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd3 || busw !== 32'hA) begin failures++; $display("FAIL sim_w1 got=%0b %0d %0h exp=1 3 a", regwr, rw, busw); end
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd4 || busw !== 32'hB) begin failures++; $display("FAIL sim_w2 got=%0b %0d %0h exp=1 4 b", regwr, rw, busw); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sim_w2_stall got=%0h exp=0", stall); end
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd31 || busw !== 32'h400) begin failures++; $display("FAIL sim_w3 got=%0b %0d %0h exp=1 31 400", regwr, rw, busw); end
    tick();
    checks++; if (regwr !== 1'b0) begin failures++; $display("FAIL sim_idle got=%0h exp=0", regwr); end
  endtask

  task automatic test_r0_filter();
    alu_vld = 1; alu_rd = 0; alu_data = 32'h99;
    ld_vld = 1; ld_rd = 0; ld_data = 32'h98;
    ra = 0; rb = 0;
    tick();
    clear_inputs();
    checks++; if (hit_a !== 1'b0 || fwd_a !== 32'd0 || hit_b !== 1'b0) begin failures++; $display("FAIL r0_nohit got=%0b %0h %0b exp=0 0 0", hit_a, fwd_a, hit_b); end
    tick();
    checks++; if (regwr !== 1'b0) begin failures++; $display("FAIL r0_noregwr got=%0h exp=0", regwr); end
    // A single real write afterwards must appear with normal latency,
    // showing the r0 attempts occupied no slot.
    alu_vld = 1; alu_rd = 9; alu_data = 32'h77;
    tick();
    clear_inputs();
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd9 || busw !== 32'h77) begin failures++; $display("FAIL r0_next_write got=%0b %0d %0h exp=1 9 77", regwr, rw, busw); end
    tick();
    checks++; if (regwr !== 1'b0) begin failures++; $display("FAIL r0_drained got=%0h exp=0", regwr); end
  endtask

  task automatic test_fwd_priority();
    ra = 7;
    alu_vld = 1; alu_rd = 7; alu_data = 32'h11;
    tick();
    checks++; if (hit_a !== 1'b1 || fwd_a !== 32'h11) begin failures++; $display("FAIL fwd_first got=%0b %0h exp=1 11", hit_a, fwd_a); end
    alu_data = 32'h22;
    tick();
    clear_inputs();
    // output register holds r7=0x11, FIFO holds r7=0x22
    checks++; if (regwr !== 1'b1 || busw !== 32'h11) begin failures++; $display("FAIL fwd_outreg got=%0b %0h exp=1 11", regwr, busw); end
    checks++; if (hit_a !== 1'b1 || fwd_a !== 32'h22) begin failures++; $display("FAIL fwd_youngest got=%0b %0h exp=1 22", hit_a, fwd_a); end
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd7 || busw !== 32'h22) begin failures++; $display("FAIL fwd_w2 got=%0b %0d %0h exp=1 7 22", regwr, rw, busw); end
    tick();
    ra = 0;
  endtask

  task automatic test_overflow();
    rb = 31;
    ld_vld = 1; ld_rd = 1; ld_data = 32'h10;
    alu_vld = 1; alu_rd = 2; alu_data = 32'h20;
    tick();   // count = 2
    checks++; if (stall !== 1'b1 || ovf !== 1'b0) begin failures++; $display("FAIL ovf_fill got stall=%0b ovf=%0b exp 1 0", stall, ovf); end
    ld_rd = 3; ld_data = 32'h30;
    alu_rd = 4; alu_data = 32'h40;
    jal_vld = 1; jal_ins = 30'h200;
    tick();   // room 2: ld and alu accepted, jal dropped
    clear_inputs();
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0h exp=1", ovf); end
    checks++; if (hit_b !== 1'b0) begin failures++; $display("FAIL ovf_dropped_jal got=%0h exp=0", hit_b); end
    checks++; if (regwr !== 1'b1 || rw !== 5'd1 || busw !== 32'h10) begin failures++; $display("FAIL ovf_d1 got=%0b %0d %0h exp=1 1 10", regwr, rw, busw); end
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd2 || busw !== 32'h20) begin failures++; $display("FAIL ovf_d2 got=%0b %0d %0h exp=1 2 20", regwr, rw, busw); end
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd3 || busw !== 32'h30) begin failures++; $display("FAIL ovf_d3 got=%0b %0d %0h exp=1 3 30", regwr, rw, busw); end
    tick();
    checks++; if (regwr !== 1'b1 || rw !== 5'd4 || busw !== 32'h40) begin failures++; $display("FAIL ovf_d4 got=%0b %0d %0h exp=1 4 40", regwr, rw, busw); end
    tick();
    checks++; if (regwr !== 1'b0 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got regwr=%0b ovf=%0b exp 0 1", regwr, ovf); end
  endtask

  task automatic test_reset_mid_drain();
    int writes;
    ra = 6;
    ld_vld = 1; ld_rd = 5; ld_data = 32'h50;
    alu_vld = 1; alu_rd = 6; alu_data = 32'h60;
    jal_vld = 1; jal_ins = 30'h3;
    tick();
    clear_inputs();
    checks++; if (stall !== 1'b1 || hit_a !== 1'b1 || fwd_a !== 32'h60) begin failures++; $display("FAIL rmid_pending got stall=%0b hit=%0b fwd=%0h exp 1 1 60", stall, hit_a, fwd_a); end
    #2;
    reset = 1;
    #1;
    checks++; if (regwr !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rmid_async got regwr=%0b stall=%0b exp 0 0", regwr, stall); end
    checks++; if (ovf !== 1'b0 || hit_a !== 1'b0 || rw !== 5'd0 || busw !== 32'd0) begin failures++; $display("FAIL rmid_clear got ovf=%0b hit=%0b rw=%0d busw=%0h exp 0 0 0 0", ovf, hit_a, rw, busw); end
    #1;
    reset = 0;
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (regwr === 1'b1) writes++;
    end
    checks++; if (writes !== 0) begin failures++; $display("FAIL rmid_nowrites got=%0d exp=0", writes); end
    ra = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_r0_filter();
    test_fwd_priority();
    test_overflow();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
